// File: rtl/pe_ctrl_fsm.sv
// Sequencer for one processing element.
// Runs a conv job (N taps of load / multiply / accumulate, optional bias beat, write-back)
// or a max-pool job (N compare beats, write-back). It then holds the result until the
// consumer takes it. All strobes are registered decodes of the state. The register-file
// write enables are the exception: they follow the live input handshake, because the
// beat must be captured in the cycle it is transferred.

module pe_ctrl_fsm #(
  parameter int unsigned TAP_W   = 5,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             use_bias,
  input  logic [TAP_W-1:0] num_taps,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       pe_resp,
  output logic             if_rf_wr_en,
  output logic             wt_rf_wr_en,
  output logic             of_rf_wr_en,
  output logic             mult_en,
  output logic             mult_load,
  output logic             add_en,
  output logic             acc_wr_en,
  output logic             acc_clr,
  output logic             actn_in_sel,
  output logic             wt_in_sel,
  output logic             add_in_sel,
  output logic             pe_out_sel,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  localparam int unsigned WC_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StClr   = 4'd1;
  localparam logic [3:0] StLoad  = 4'd2;
  localparam logic [3:0] StMload = 4'd3;
  localparam logic [3:0] StMwait = 4'd4;
  localparam logic [3:0] StAwait = 4'd5;
  localparam logic [3:0] StAccw  = 4'd6;
  localparam logic [3:0] StBload = 4'd7;
  localparam logic [3:0] StBwait = 4'd8;
  localparam logic [3:0] StBaccw = 4'd9;
  localparam logic [3:0] StPcmp  = 4'd10;
  localparam logic [3:0] StWrb   = 4'd11;
  localparam logic [3:0] StDone  = 4'd12;

  logic [3:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic             bias_q, bias_d;
  logic [TAP_W-1:0] taps_q, taps_d;
  logic [TAP_W-1:0] tap_cnt_q, tap_cnt_d;
  logic [TAP_W-1:0] tap_nxt;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             timeout;
  logic             transfer;

  // Registered strobe copies and their next-state decodes
  logic in_ready_q, in_ready_d;
  logic of_wr_q, of_wr_d;
  logic mult_en_q, mult_en_d;
  logic mult_load_q, mult_load_d;
  logic add_en_q, add_en_d;
  logic acc_wr_q, acc_wr_d;
  logic acc_clr_q, acc_clr_d;
  logic actn_sel_q, actn_sel_d;
  logic wt_sel_q, wt_sel_d;
  logic add_sel_q, add_sel_d;
  logic out_sel_q, out_sel_d;
  logic busy_q, busy_d;
  logic out_valid_q, out_valid_d;

  assign transfer = in_ready_q & in_valid;
  assign tap_nxt  = tap_cnt_q + TAP_W'(1);
  assign timeout  = (wait_cnt_q == WC_W'(TMO_CYC - 1));

  // Next-state, job configuration, tap/wait counters and sticky error
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bias_d    = bias_q;
    taps_d    = taps_q;
    tap_cnt_d = tap_cnt_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_taps == '0) begin
            err_d = 1'b1;
          end else begin
            mode_d    = mode;
            bias_d    = use_bias;
            taps_d    = num_taps;
            tap_cnt_d = '0;
            err_d     = 1'b0;
            state_d   = StClr;
          end
        end
      end
      StClr:   state_d = StLoad;
      StLoad: begin
        if (transfer) state_d = mode_q ? StPcmp : StMload;
      end
      StMload: state_d = StMwait;
      StMwait: begin
        if (pe_resp[0]) begin
          state_d = StAwait;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StAwait: begin
        if (pe_resp[1]) begin
          state_d = StAccw;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StAccw: begin
        tap_cnt_d = tap_nxt;
        if (tap_nxt == taps_q) state_d = bias_q ? StBload : StWrb;
        else                   state_d = StLoad;
      end
      StBload: begin
        if (transfer) state_d = StBwait;
      end
      StBwait: begin
        if (pe_resp[1]) begin
          state_d = StBaccw;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StBaccw: state_d = StWrb;
      StPcmp: begin
        tap_cnt_d = tap_nxt;
        state_d   = (tap_nxt == taps_q) ? StWrb : StLoad;
      end
      StWrb:   state_d = StDone;
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Any state change restarts the wait counter, so every wait state starts from zero
    wait_cnt_d = (state_d != state_q) ? '0 : wait_cnt_q + WC_W'(1);
  end

  // Strobe decode of the upcoming state; registered below so outputs are glitch-free
  always_comb begin
    in_ready_d  = 1'b0;
    of_wr_d     = 1'b0;
    mult_en_d   = 1'b0;
    mult_load_d = 1'b0;
    add_en_d    = 1'b0;
    acc_wr_d    = 1'b0;
    acc_clr_d   = 1'b0;
    actn_sel_d  = 1'b0;
    wt_sel_d    = 1'b0;
    add_sel_d   = 1'b0;
    out_sel_d   = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = (state_d != StIdle);
    case (state_d)
      StClr:   acc_clr_d   = 1'b1;
      StLoad:  in_ready_d  = 1'b1;
      StMload: mult_load_d = 1'b1;
      StMwait: mult_en_d   = 1'b1;
      StAwait: add_en_d    = 1'b1;
      StAccw:  acc_wr_d    = 1'b1;
      StBload: in_ready_d  = 1'b1;
      StBwait: begin
        wt_sel_d  = 1'b1;
        add_sel_d = 1'b1;
        add_en_d  = 1'b1;
      end
      StBaccw: acc_wr_d    = 1'b1;
      StPcmp:  actn_sel_d  = 1'b1;
      StWrb: begin
        of_wr_d   = 1'b1;
        out_sel_d = mode_d;
      end
      StDone:  out_valid_d = 1'b1;
      default: ;
    endcase
  end

  // State, configuration and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      bias_q     <= 1'b0;
      taps_q     <= '0;
      tap_cnt_q  <= '0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      bias_q     <= bias_d;
      taps_q     <= taps_d;
      tap_cnt_q  <= tap_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q  <= 1'b0;
      of_wr_q     <= 1'b0;
      mult_en_q   <= 1'b0;
      mult_load_q <= 1'b0;
      add_en_q    <= 1'b0;
      acc_wr_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      actn_sel_q  <= 1'b0;
      wt_sel_q    <= 1'b0;
      add_sel_q   <= 1'b0;
      out_sel_q   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      of_wr_q     <= of_wr_d;
      mult_en_q   <= mult_en_d;
      mult_load_q <= mult_load_d;
      add_en_q    <= add_en_d;
      acc_wr_q    <= acc_wr_d;
      acc_clr_q   <= acc_clr_d;
      actn_sel_q  <= actn_sel_d;
      wt_sel_q    <= wt_sel_d;
      add_sel_q   <= add_sel_d;
      out_sel_q   <= out_sel_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  // Weight RF takes the filter beat in conv LOAD and the bias beat in BLOAD
  assign if_rf_wr_en = transfer & (state_q == StLoad);
  assign wt_rf_wr_en = transfer & (((state_q == StLoad) & ~mode_q) | (state_q == StBload));
  assign of_rf_wr_en = of_wr_q;
  assign mult_en     = mult_en_q;
  assign mult_load   = mult_load_q;
  assign add_en      = add_en_q;
  assign acc_wr_en   = acc_wr_q;
  assign acc_clr     = acc_clr_q;
  assign actn_in_sel = actn_sel_q;
  assign wt_in_sel   = wt_sel_q;
  assign add_in_sel  = add_sel_q;
  assign pe_out_sel  = out_sel_q;
  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pe_ctrl_fsm.sv
// Bench for pe_ctrl_fsm. Each job is unrolled up front into a per-cycle list of input
// vectors and expected outputs, from the job description and the PE response delays.
// One loop then applies and checks them cycle by cycle. Pulse counts gathered from the
// DUT are also pinned against hand-computed literals.

module tb_pe_ctrl_fsm;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, mode = 1'b0, use_bias = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0] num_taps = '0;
  logic [1:0] pe_resp = '0;
  logic in_ready, if_rf_wr_en, wt_rf_wr_en, of_rf_wr_en, mult_en, mult_load, add_en;
  logic acc_wr_en, acc_clr, actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel, busy;
  logic out_valid, err;

  pe_ctrl_fsm #(.TAP_W(5), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .use_bias(use_bias),
    .num_taps(num_taps), .in_valid(in_valid), .in_ready(in_ready), .pe_resp(pe_resp),
    .if_rf_wr_en(if_rf_wr_en), .wt_rf_wr_en(wt_rf_wr_en), .of_rf_wr_en(of_rf_wr_en),
    .mult_en(mult_en), .mult_load(mult_load), .add_en(add_en), .acc_wr_en(acc_wr_en),
    .acc_clr(acc_clr), .actn_in_sel(actn_in_sel), .wt_in_sel(wt_in_sel),
    .add_in_sel(add_in_sel), .pe_out_sel(pe_out_sel), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic in_ready, if_wr, wt_wr, of_wr, mult_en, mult_load, add_en, acc_wr, acc_clr;
    logic actn_sel, wt_sel, add_sel, out_sel, busy, out_valid, err;
  } outs_t;

  typedef struct {
    logic       rst_n, start, mode, use_bias, in_valid, out_ready;
    logic [4:0] taps;
    logic [1:0] resp;
    outs_t      exp;
  } vec_t;

  vec_t  q[$];
  int    n_chk = 0, n_fail = 0, vec_no = 0;
  string cur = "";
  // Job configuration presented with every pushed vector
  logic  c_mode = 0, c_bias = 0, c_rst = 1;
  logic [4:0] c_taps = '0;
  logic  m_err = 0;
  // Pulse counters over the current scenario, read from the DUT
  int n_clr, n_mload, n_accw, n_ofwr, n_ifwr, n_wtwr, n_actn, n_ovalid, n_men, n_bw;
  int wrb_sel;

  function automatic outs_t idle_o();
    outs_t o = '0;
    o.err = m_err;
    return o;
  endfunction

  function automatic outs_t busy_o();
    outs_t o = '0;
    o.busy = 1'b1;
    o.err  = m_err;
    return o;
  endfunction

  task automatic push(input logic st, input logic iv, input logic [1:0] rs, input logic ordy,
                      input outs_t e);
    vec_t v;
    v.rst_n = c_rst; v.start = st; v.mode = c_mode; v.use_bias = c_bias; v.taps = c_taps;
    v.in_valid = iv; v.resp = rs; v.out_ready = ordy; v.exp = e;
    q.push_back(v);
  endtask

  // One accepted beat after `gap` idle cycles; bias_beat selects the BLOAD flavour
  task automatic gen_beat(input int gap, input logic bias_beat, input logic [1:0] nz);
    outs_t o = busy_o();
    o.in_ready = 1'b1;
    for (int g = 0; g < gap; g++) push(1'b0, 1'b0, nz, 1'b0, o);
    if (bias_beat) begin
      o.wt_wr = 1'b1;
    end else begin
      o.if_wr = 1'b1;
      o.wt_wr = ~c_mode;
    end
    push(1'b0, 1'b1, nz, 1'b0, o);
  endtask

  // A wait of `dly` unanswered cycles followed by the answering cycle
  task automatic gen_wait(input outs_t o, input int dly, input logic [1:0] quiet,
                          input logic [1:0] hit);
    for (int i = 0; i < dly; i++) push(1'b0, 1'b0, quiet, 1'b0, o);
    push(1'b0, 1'b0, hit, 1'b0, o);
  endtask

  task automatic gen_job(input logic md, input logic bias, input int taps, input int mdly,
                         input int adly, input int gap, input int dwait, input logic dstart,
                         input logic noise);
    outs_t o;
    logic [1:0] nz;
    nz = noise ? 2'b11 : 2'b00;
    c_mode = md; c_bias = bias; c_taps = 5'(taps); c_rst = 1'b1;
    push(1'b1, 1'b0, nz, 1'b0, idle_o());
    m_err = 1'b0;
    o = busy_o(); o.acc_clr = 1'b1; push(1'b0, 1'b0, nz, 1'b0, o);
    for (int t = 0; t < taps; t++) begin
      gen_beat(gap, 1'b0, nz);
      if (!md) begin
        o = busy_o(); o.mult_load = 1'b1; push(1'b0, 1'b0, nz, 1'b0, o);
        o = busy_o(); o.mult_en = 1'b1;
        gen_wait(o, mdly, noise ? 2'b10 : 2'b00, noise ? 2'b11 : 2'b01);
        o = busy_o(); o.add_en = 1'b1;
        gen_wait(o, adly, noise ? 2'b01 : 2'b00, noise ? 2'b11 : 2'b10);
        o = busy_o(); o.acc_wr = 1'b1; push(1'b0, 1'b0, nz, 1'b0, o);
      end else begin
        o = busy_o(); o.actn_sel = 1'b1; push(1'b0, 1'b0, nz, 1'b0, o);
      end
    end
    if (bias && !md) begin
      gen_beat(gap, 1'b1, nz);
      o = busy_o(); o.wt_sel = 1'b1; o.add_sel = 1'b1; o.add_en = 1'b1;
      gen_wait(o, adly, noise ? 2'b01 : 2'b00, noise ? 2'b11 : 2'b10);
      o = busy_o(); o.acc_wr = 1'b1; push(1'b0, 1'b0, nz, 1'b0, o);
    end
    o = busy_o(); o.of_wr = 1'b1; o.out_sel = md; push(1'b0, 1'b0, nz, 1'b0, o);
    o = busy_o(); o.out_valid = 1'b1;
    for (int i = 0; i < dwait; i++) push(dstart, 1'b0, nz, 1'b0, o);
    push(1'b0, 1'b0, nz, 1'b1, o);
    push(1'b0, 1'b0, nz, 1'b0, idle_o());
  endtask

  // Conv job whose multiplier never answers
  task automatic gen_tmo(input int taps);
    outs_t o;
    c_mode = 1'b0; c_bias = 1'b0; c_taps = 5'(taps); c_rst = 1'b1;
    push(1'b1, 1'b0, 2'b00, 1'b0, idle_o());
    m_err = 1'b0;
    o = busy_o(); o.acc_clr = 1'b1; push(1'b0, 1'b0, 2'b00, 1'b0, o);
    gen_beat(0, 1'b0, 2'b00);
    o = busy_o(); o.mult_load = 1'b1; push(1'b0, 1'b0, 2'b00, 1'b0, o);
    o = busy_o(); o.mult_en = 1'b1;
    for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, 2'b10, 1'b0, o);
    m_err = 1'b1;
    push(1'b0, 1'b0, 2'b00, 1'b0, idle_o());
    push(1'b0, 1'b0, 2'b00, 1'b0, idle_o());
  endtask

  // Conv job cut short by reset in AWAIT, with start held high during reset
  task automatic gen_rst_mid();
    outs_t o;
    c_mode = 1'b0; c_bias = 1'b0; c_taps = 5'd2; c_rst = 1'b1;
    push(1'b1, 1'b0, 2'b00, 1'b0, idle_o());
    m_err = 1'b0;
    o = busy_o(); o.acc_clr = 1'b1; push(1'b0, 1'b0, 2'b00, 1'b0, o);
    gen_beat(0, 1'b0, 2'b00);
    o = busy_o(); o.mult_load = 1'b1; push(1'b0, 1'b0, 2'b00, 1'b0, o);
    o = busy_o(); o.mult_en = 1'b1; push(1'b0, 1'b0, 2'b01, 1'b0, o);
    o = busy_o(); o.add_en = 1'b1;
    push(1'b0, 1'b0, 2'b00, 1'b0, o);
    push(1'b0, 1'b0, 2'b00, 1'b0, o);
    c_rst = 1'b0;
    push(1'b1, 1'b0, 2'b00, 1'b0, '0);
    push(1'b1, 1'b0, 2'b00, 1'b0, '0);
    c_rst = 1'b1;
    push(1'b0, 1'b0, 2'b00, 1'b0, idle_o());
    push(1'b0, 1'b0, 2'b00, 1'b0, idle_o());
  endtask

  task automatic clr_cnt();
    n_clr = 0; n_mload = 0; n_accw = 0; n_ofwr = 0; n_ifwr = 0; n_wtwr = 0;
    n_actn = 0; n_ovalid = 0; n_men = 0; n_bw = 0; wrb_sel = -1;
  endtask

  // Apply queued vectors at the falling edge and check outputs shortly after
  task automatic run_q();
    vec_t  v;
    outs_t got;
    while (q.size() > 0) begin
      @(negedge clk);
      v = q.pop_front();
      rst = v.rst_n; start = v.start; mode = v.mode; use_bias = v.use_bias;
      num_taps = v.taps; in_valid = v.in_valid; pe_resp = v.resp; out_ready = v.out_ready;
      #1;
      got = {in_ready, if_rf_wr_en, wt_rf_wr_en, of_rf_wr_en, mult_en, mult_load, add_en,
             acc_wr_en, acc_clr, actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel, busy,
             out_valid, err};
      n_chk++;
      if (got !== v.exp) begin
        n_fail++;
        $display("FAIL %s vec %0d: outputs got %b, expected %b", cur, vec_no, got, v.exp);
      end
      vec_no++;
      n_clr += int'(acc_clr); n_mload += int'(mult_load); n_accw += int'(acc_wr_en);
      n_ofwr += int'(of_rf_wr_en); n_ifwr += int'(if_rf_wr_en); n_wtwr += int'(wt_rf_wr_en);
      n_actn += int'(actn_in_sel); n_ovalid += int'(out_valid); n_men += int'(mult_en);
      n_bw += int'(wt_in_sel & add_in_sel & add_en);
      if (of_rf_wr_en) wrb_sel = int'(pe_out_sel);
    end
  endtask

  task automatic lit(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", cur, nm, got, exp);
    end
  endtask

  initial begin
    cur = "reset";
    m_err = 1'b0; c_rst = 1'b0;
    push(1'b0, 1'b0, 2'b00, 1'b0, '0);
    push(1'b1, 1'b0, 2'b00, 1'b0, '0);
    c_rst = 1'b1;
    push(1'b0, 1'b0, 2'b00, 1'b0, idle_o());
    run_q();

    cur = "conv3"; clr_cnt();
    gen_job(1'b0, 1'b0, 3, 2, 2, 0, 0, 1'b0, 1'b0); run_q();
    lit("acc_clr", n_clr, 1); lit("mult_load", n_mload, 3); lit("acc_wr", n_accw, 3);
    lit("of_wr", n_ofwr, 1); lit("out_sel", wrb_sel, 0); lit("out_valid", n_ovalid, 1);

    cur = "conv1_bias"; clr_cnt();
    gen_job(1'b0, 1'b1, 1, 1, 0, 0, 0, 1'b0, 1'b0); run_q();
    lit("acc_wr", n_accw, 2); lit("wt_wr", n_wtwr, 2); lit("if_wr", n_ifwr, 1);
    lit("bwait", n_bw, 1);

    cur = "pool4_gap"; clr_cnt();
    gen_job(1'b1, 1'b0, 4, 0, 0, 2, 0, 1'b0, 1'b0); run_q();
    lit("if_wr", n_ifwr, 4); lit("wt_wr", n_wtwr, 0); lit("actn_sel", n_actn, 4);
    lit("out_sel", wrb_sel, 1); lit("mult_load", n_mload, 0);

    cur = "timeout"; clr_cnt();
    gen_tmo(2); run_q();
    lit("of_wr", n_ofwr, 0); lit("mult_en", n_men, 64); lit("err", int'(err), 1);

    cur = "zero_taps"; clr_cnt();
    c_taps = 5'd0; c_mode = 1'b0; c_bias = 1'b0;
    push(1'b1, 1'b0, 2'b00, 1'b0, idle_o());
    m_err = 1'b1;
    push(1'b0, 1'b0, 2'b00, 1'b0, idle_o());
    run_q();
    lit("err", int'(err), 1); lit("busy", int'(busy), 0);

    // out_ready low for 5 DONE cycles, then high: out_valid spans those 5 plus the accept
    cur = "done_hold"; clr_cnt();
    gen_job(1'b1, 1'b0, 2, 0, 0, 0, 5, 1'b1, 1'b0); run_q();
    lit("out_valid", n_ovalid, 6); lit("of_wr", n_ofwr, 1); lit("err", int'(err), 0);

    cur = "resp_at_limit"; clr_cnt();
    gen_job(1'b0, 1'b0, 1, TMO - 1, 1, 0, 0, 1'b0, 1'b0); run_q();
    lit("acc_wr", n_accw, 1); lit("of_wr", n_ofwr, 1); lit("err", int'(err), 0);

    cur = "pool_max"; clr_cnt();
    gen_job(1'b1, 1'b0, 31, 0, 0, 0, 0, 1'b0, 1'b1); run_q();
    lit("if_wr", n_ifwr, 31); lit("actn_sel", n_actn, 31);

    cur = "rst_mid"; clr_cnt();
    gen_rst_mid(); run_q();
    lit("of_wr", n_ofwr, 0); lit("acc_wr", n_accw, 0);

    cur = "conv2_bias_noise"; clr_cnt();
    gen_job(1'b0, 1'b1, 2, 1, 1, 1, 1, 1'b0, 1'b1); run_q();
    lit("acc_wr", n_accw, 3); lit("wt_wr", n_wtwr, 3); lit("of_wr", n_ofwr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
